// File: rtl/seq_frame_tx_if.sv
// Bus bundle for seq_frame_tx: frame request/latch inputs, bit strobe and the
// serial line/status outputs. master = transmitter side, slave = driver/receiver side.
interface seq_frame_tx_if #(
  parameter int unsigned DATA_W = 16
);
  logic              clk_en;
  logic              start;
  logic [3:0]        len;
  logic [DATA_W-1:0] data_in;
  logic              ser_out;
  logic              ser_out_valid;
  logic              busy;
  logic              done;
  logic [3:0]        cnt_out;

  modport master (
    input  clk_en, start, len, data_in,
    output ser_out, ser_out_valid, busy, done, cnt_out
  );

  modport slave (
    output clk_en, start, len, data_in,
    input  ser_out, ser_out_valid, busy, done, cnt_out
  );
endinterface

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: sync pattern, 4-bit length, then payload, one bit per clk_en.
// Optional trailing even-parity bit when SEQ_TX_PARITY_EN is defined.
module seq_frame_tx #(
  parameter int unsigned       SYNC_W   = 4,
  parameter logic [SYNC_W-1:0] SYNC_PAT = 4'b1101,
  parameter int unsigned       DATA_W   = 16
) (
  input  logic           clk,
  input  logic           rst,
  seq_frame_tx_if.master bus
);

  localparam int unsigned IDX_W = (SYNC_W > 16) ? $clog2(SYNC_W) : 4;

  if (DATA_W < 15) begin : g_data_w_check
    $error("seq_frame_tx: DATA_W must be >= 15");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_LEN,
    S_DATA,
`ifdef SEQ_TX_PARITY_EN
    S_PAR,
`endif
    S_DONE
  } state_t;

`ifdef SEQ_TX_PARITY_EN
  localparam state_t S_END = S_PAR;
`else
  localparam state_t S_END = S_DONE;
`endif

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [3:0]        len_q, len_d;
  logic [DATA_W-1:0] data_q, data_d;
`ifdef SEQ_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  logic       cur_bit;
  logic       valid;
  logic       busy;
  logic       done;
  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      data_q  <= '0;
`ifdef SEQ_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      data_q  <= data_d;
`ifdef SEQ_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Bit on the line and status; remaining payload count in DATA is idx+1.
  always_comb begin
    cur_bit = 1'b1;
    valid   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    cnt     = '0;
    case (state_q)
      S_SYNC: begin
        valid = 1'b1;
        busy  = 1'b1;
        cnt   = len_q;
        for (int unsigned i = 0; i < SYNC_W; i++)
          if (i == 32'(idx_q)) cur_bit = SYNC_PAT[i];
      end
      S_LEN: begin
        valid = 1'b1;
        busy  = 1'b1;
        cnt   = len_q;
        for (int unsigned i = 0; i < 4; i++)
          if (i == 32'(idx_q)) cur_bit = len_q[i];
      end
      S_DATA: begin
        valid = 1'b1;
        busy  = 1'b1;
        cnt   = 4'(idx_q + IDX_W'(1));
        for (int unsigned i = 0; i < DATA_W; i++)
          if (i == 32'(idx_q)) cur_bit = data_q[i];
      end
`ifdef SEQ_TX_PARITY_EN
      S_PAR: begin
        valid   = 1'b1;
        busy    = 1'b1;
        cur_bit = par_q;
      end
`endif
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    data_d  = data_q;
`ifdef SEQ_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          len_d   = bus.len;
          data_d  = bus.data_in;
          idx_d   = IDX_W'(SYNC_W - 1);
          state_d = S_SYNC;
`ifdef SEQ_TX_PARITY_EN
          par_d   = ^bus.len;
`endif
        end
      end
      S_SYNC: begin
        if (bus.clk_en) begin
          if (idx_q == '0) begin
            state_d = S_LEN;
            idx_d   = IDX_W'(3);
          end else begin
            idx_d = idx_q - IDX_W'(1);
          end
        end
      end
      S_LEN: begin
        if (bus.clk_en) begin
          if (idx_q != '0) begin
            idx_d = idx_q - IDX_W'(1);
          end else if (len_q == '0) begin
            state_d = S_END;
          end else begin
            state_d = S_DATA;
            idx_d   = IDX_W'(len_q) - IDX_W'(1);
          end
        end
      end
      S_DATA: begin
        if (bus.clk_en) begin
`ifdef SEQ_TX_PARITY_EN
          par_d = par_q ^ cur_bit;
`endif
          if (idx_q == '0) state_d = S_END;
          else             idx_d   = idx_q - IDX_W'(1);
        end
      end
`ifdef SEQ_TX_PARITY_EN
      S_PAR: begin
        if (bus.clk_en) state_d = S_DONE;
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.ser_out       = cur_bit;
  assign bus.ser_out_valid = valid;
  assign bus.busy          = busy;
  assign bus.done          = done;
  assign bus.cnt_out       = cnt;

endmodule
